// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage latch feeding a register file with bypassed read ports
module wb_regfile #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic          wb_we,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata
);
  logic          wb_we_q, wb_we_d;
  logic [AW-1:0] wb_waddr_q, wb_waddr_d;
  logic [DW-1:0] wb_wdata_q, wb_wdata_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  // next WB latch contents and the array after this cycle's commit (writes to r0 dropped)
  always_comb begin
    wb_we_d    = mem_we;
    wb_waddr_d = mem_waddr;
    wb_wdata_d = mem_wdata;
    regs_d     = regs_q;
    if (wb_we_q && wb_waddr_q != '0) regs_d[wb_waddr_q] = wb_wdata_q;
  end
  // WB latch and array; reset discards the in-flight write and clears every register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      regs_q     <= regs_d;
    end
  end
  // read ports: disabled or r0 give zero, then the value being committed, then the array
  always_comb begin
    rdata1 = (!re1 || raddr1 == '0) ? '0 : (wb_we_q && wb_waddr_q == raddr1) ? wb_wdata_q : regs_q[raddr1];
    rdata2 = (!re2 || raddr2 == '0) ? '0 : (wb_we_q && wb_waddr_q == raddr2) ? wb_wdata_q : regs_q[raddr2];
  end
  assign wb_we    = wb_we_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_wdata = wb_wdata_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of wb_regfile against a behavioural model
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_we = 1'b0;
  logic [4:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic        re1 = 1'b0, re2 = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic [31:0] rdata1, rdata2, wb_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  int n_chk = 0, n_fail = 0;
  bit go = 1'b0;

  wb_regfile dut (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  // model: register contents plus the one write that is waiting to be committed
  logic [31:0] m [32];
  logic        p_we;
  logic [4:0]  p_a;
  logic [31:0] p_d;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m[i] <= '0;
      p_we <= 1'b0;
      p_a  <= '0;
      p_d  <= '0;
    end else begin
      if (p_we && p_a != 0) m[p_a] <= p_d;
      p_we <= mem_we;
      p_a  <= mem_waddr;
      p_d  <= mem_wdata;
    end
  end

  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    if (!en || a == 0) return 32'h0;
    if (p_we && p_a == a) return p_d;
    return m[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (go) begin
    chk("cmp_rdata1", rdata1, model_read(re1, raddr1));
    chk("cmp_rdata2", rdata2, model_read(re2, raddr2));
    chk("cmp_wb_we", {31'b0, wb_we}, {31'b0, p_we});
    chk("cmp_wb_waddr", {27'b0, wb_waddr}, {27'b0, p_a});
    chk("cmp_wb_wdata", wb_wdata, p_d);
  end

  task automatic apply(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    @(posedge clk);
    #1;
    mem_we = we; mem_waddr = wa; mem_wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    go = 1'b1;
    #2;
    chk("reset_wb_we", {31'b0, wb_we}, 32'h0);
    chk("reset_wb_wdata", wb_wdata, 32'h0);
    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; re2 = 1'b1; raddr1 = a[4:0]; raddr2 = a[4:0];
      #1;
      chk("reset_read1", rdata1, 32'h0);
      chk("reset_read2", rdata2, 32'h0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    // single write: bypass in cycle 1, array in cycle 2
    apply(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 5, 0, 0);
    at_neg();
    chk("bypass_rdata1", rdata1, 32'hDEADBEEF);
    chk("bypass_wb_we", {31'b0, wb_we}, 32'h1);
    apply(0, 0, 0, 0, 0, 1, 5);
    at_neg();
    chk("array_rdata2", rdata2, 32'hDEADBEEF);
    // writes to r0 are dropped
    apply(1, 0, 32'h12345678, 1, 0, 1, 0);
    apply(0, 0, 0, 1, 0, 1, 0);
    at_neg();
    chk("r0_wb_we", {31'b0, wb_we}, 32'h1);
    chk("r0_wb_waddr", {27'b0, wb_waddr}, 32'h0);
    chk("r0_rdata1_c1", rdata1, 32'h0);
    chk("r0_rdata2_c1", rdata2, 32'h0);
    for (int c = 2; c <= 3; c++) begin
      apply(0, 0, 0, 1, 0, 1, 0);
      at_neg();
      chk("r0_rdata1", rdata1, 32'h0);
      chk("r0_rdata2", rdata2, 32'h0);
    end
    // back-to-back writes to r7
    for (int c = 0; c < 5; c++) begin
      automatic logic [31:0] wv = c + 1;
      automatic logic [31:0] ev = (c < 3) ? c : 3;
      apply(c < 3, 7, wv, 1, 7, 0, 0);
      at_neg();
      chk("b2b_r7", rdata1, ev);
    end
    // disabled port reads zero while the other reads r7
    apply(0, 0, 0, 0, 7, 1, 7);
    at_neg();
    chk("re1_off", rdata1, 32'h0);
    chk("re2_on", rdata2, 32'h3);
    // reset mid-cycle discards the in-flight write to r9
    apply(1, 9, 32'hAA, 1, 9, 1, 9);
    apply(0, 0, 0, 1, 9, 1, 9);
    at_neg();
    chk("pre_rst_wb_we", {31'b0, wb_we}, 32'h1);
    chk("pre_rst_bypass", rdata1, 32'hAA);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_wb_we", {31'b0, wb_we}, 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    reset_n = 1'b1;
    apply(0, 0, 0, 1, 9, 1, 9);
    at_neg();
    chk("post_rst_r9_1", rdata1, 32'h0);
    chk("post_rst_r9_2", rdata2, 32'h0);
    // randomized traffic with occasional mid-cycle reset pulses
    for (int c = 0; c < 600; c++) begin
      apply($urandom_range(0, 9) < 6,
            $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom),
            $urandom,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom),
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        #5 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    at_neg();
    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
